// File: rtl/muldiv_alu.sv
// muldiv_alu -- single-issue integer ALU with an iterative multiply/divide unit.
//
// Ops 0-9 (add/sub/logic/shift/compare) complete one cycle after the request
// is accepted. Ops 10-13 (MUL family) use a shift-add loop and ops 14-17
// (DIV family) use a restoring divider. Both retire one bit per cycle over
// XLEN cycles. Divide-by-zero, signed overflow and unknown opcodes resolve
// on the single-cycle path.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   flush         drop whatever is in flight or held, back to IDLE
//   in_valid/in_ready, opcode, left, right   request handshake and operands
//   out_valid/out_ready, result              response handshake and data
module muldiv_alu #(
   parameter int XLEN = 32,
   parameter int OP_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] opcode,
   input  logic [XLEN-1:0] left,
   input  logic [XLEN-1:0] right,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int SW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0),  OP_SUB    = OP_W'(1),  OP_AND   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(3),  OP_XOR    = OP_W'(4),  OP_SLL   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6),  OP_SRA    = OP_W'(7),  OP_SLT   = OP_W'(8);
   localparam logic [OP_W-1:0] OP_SLTU = OP_W'(9),  OP_MUL    = OP_W'(10), OP_MULH  = OP_W'(11);
   localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(12), OP_MULHU = OP_W'(13), OP_DIV  = OP_W'(14);
   localparam logic [OP_W-1:0] OP_DIVU = OP_W'(15), OP_REM    = OP_W'(16), OP_REMU  = OP_W'(17);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   // hi/lo: product high/low halves, or remainder/quotient for division.
   // b: multiplicand or divisor magnitude.
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
   logic            neg_q, neg_d;   // final result needs two's-complement fixup

   logic            accept, is_mul_in, is_div_in, dz, ovf;
   logic            l_sgn, r_sgn, l_neg, r_neg;
   logic [XLEN-1:0] l_mag, r_mag, alu_res;
   logic [SW-1:0]   shamt;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_prod, mul_fix;
   logic [XLEN:0]     div_rs;
   logic              div_ge;
   logic [XLEN-1:0]   div_r, div_q, fin_res;
   logic              op_is_mul;

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = (state_q == S_DONE);
   assign result    = (state_q == S_DONE) ? res_q : '0;
   assign accept    = in_valid && in_ready && !flush;
   assign shamt     = right[SW-1:0];

   // Request decode and single-cycle results
   always_comb begin
      is_mul_in = (opcode >= OP_MUL) && (opcode <= OP_MULHU);
      is_div_in = (opcode >= OP_DIV) && (opcode <= OP_REMU);
      l_sgn = (opcode == OP_MULH) || (opcode == OP_MULHSU) || (opcode == OP_DIV) || (opcode == OP_REM);
      r_sgn = (opcode == OP_MULH) || (opcode == OP_DIV) || (opcode == OP_REM);
      l_neg = l_sgn && left[XLEN-1];
      r_neg = r_sgn && right[XLEN-1];
      l_mag = l_neg ? -left : left;
      r_mag = r_neg ? -right : right;
      dz    = (right == '0);
      ovf   = ((opcode == OP_DIV) || (opcode == OP_REM)) && (left == MIN_NEG) && (right == '1);

      alu_res = '0;
      case (opcode)
         OP_ADD:  alu_res = left + right;
         OP_SUB:  alu_res = left - right;
         OP_AND:  alu_res = left & right;
         OP_OR:   alu_res = left | right;
         OP_XOR:  alu_res = left ^ right;
         OP_SLL:  alu_res = left << shamt;
         OP_SRL:  alu_res = left >> shamt;
         OP_SRA:  alu_res = $signed(left) >>> shamt;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(left) < $signed(right)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, left < right};
         // Only the early-out division cases land here: /0 or signed overflow
         OP_DIV, OP_DIVU: alu_res = dz ? '1 : left;
         OP_REM, OP_REMU: alu_res = dz ? left : '0;
         default: alu_res = '0;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      op_is_mul = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      mul_prod  = {mul_sum, lo_q[XLEN-1:1]};
      mul_fix   = neg_q ? -mul_prod : mul_prod;
      // hi_q < b_q always holds, so the shifted partial remainder minus
      // the divisor fits back into XLEN bits.
      div_rs    = {hi_q, lo_q[XLEN-1]};
      div_ge    = div_rs >= {1'b0, b_q};
      div_r     = div_ge ? (div_rs[XLEN-1:0] - b_q) : div_rs[XLEN-1:0];
      div_q     = {lo_q[XLEN-2:0], div_ge};

      if (op_is_mul)
         fin_res = (op_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
      else if ((op_q == OP_DIV) || (op_q == OP_DIVU))
         fin_res = neg_q ? -div_q : div_q;
      else
         fin_res = neg_q ? -div_r : div_r;
   end

   // Next-state
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      neg_d   = neg_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: if (accept) begin
            op_d  = opcode;
            cnt_d = '0;
            hi_d  = '0;
            // Remainder takes the dividend's sign; everything else the xor
            neg_d = ((opcode == OP_REM) || (opcode == OP_REMU)) ? l_neg : (l_neg ^ r_neg);
            if (is_mul_in) begin
               lo_d    = r_mag;
               b_d     = l_mag;
               state_d = S_BUSY;
            end else if (is_div_in && !dz && !ovf) begin
               lo_d    = l_mag;
               b_d     = r_mag;
               state_d = S_BUSY;
            end else begin
               res_d   = alu_res;
               state_d = S_DONE;
            end
         end
         S_BUSY: begin
            hi_d  = op_is_mul ? mul_prod[2*XLEN-1:XLEN] : div_r;
            lo_d  = op_is_mul ? mul_prod[XLEN-1:0] : div_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SW'(XLEN-1)) begin
               res_d   = fin_res;
               state_d = S_DONE;
            end
         end
         S_DONE: if (out_ready) begin
            res_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         res_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_muldiv_alu.sv
// tb_muldiv_alu -- directed bench for muldiv_alu at XLEN=32 and XLEN=8.
// Expected results are queued at request time and compared when the DUT
// presents a result that the consumer accepts.
module tb_muldiv_alu;

   localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, XOR = 5'd4, SLL = 5'd5, SRL = 5'd6;
   localparam logic [4:0] SRA = 5'd7, SLT = 5'd8, SLTU = 5'd9, MUL = 5'd10, MULH = 5'd11;
   localparam logic [4:0] MULHSU = 5'd12, MULHU = 5'd13, DIV = 5'd14, DIVU = 5'd15;
   localparam logic [4:0] REM = 5'd16, REMU = 5'd17;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush;
   logic        iv32, ir32, ov32, or32;
   logic [4:0]  op32;
   logic [31:0] l32, r32, res32;
   logic        iv8, ir8, ov8, or8;
   logic [4:0]  op8;
   logic [7:0]  l8, r8, res8;

   int checks = 0;
   int errors = 0;
   logic [31:0] q32[$];
   logic [7:0]  q8[$];

   muldiv_alu #(.XLEN(32), .OP_W(5)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(iv32), .in_ready(ir32),
      .opcode(op32), .left(l32), .right(r32), .out_valid(ov32), .out_ready(or32),
      .result(res32));

   muldiv_alu #(.XLEN(8), .OP_W(5)) dut8 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(iv8), .in_ready(ir8),
      .opcode(op8), .left(l8), .right(r8), .out_valid(ov8), .out_ready(or8),
      .result(res8));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: compare each accepted result against the oldest expectation
   always @(negedge clk) begin
      if (rst === 1'b0 && ov32 === 1'b1 && or32 === 1'b1) begin
         if (q32.size() == 0) check("spurious_out32", 64'(ov32), 64'(0));
         else check("result32", 64'(res32), 64'(q32.pop_front()));
      end
      if (rst === 1'b0 && ov8 === 1'b1 && or8 === 1'b1) begin
         if (q8.size() == 0) check("spurious_out8", 64'(ov8), 64'(0));
         else check("result8", 64'(res8), 64'(q8.pop_front()));
      end
   end

   // Issue one request, push its expectation, and measure cycles to out_valid
   task automatic run_op(input bit w8, input logic [4:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] exp, input int lat, input string tag);
      int n = 0;
      while (!(w8 ? ir8 : ir32) && n < 100) begin @(posedge clk); #1; n++; end
      check({tag, "_in_ready"}, 64'(w8 ? ir8 : ir32), 64'(1));
      if (w8) begin
         iv8 = 1'b1; op8 = op; l8 = l[7:0]; r8 = r[7:0]; q8.push_back(exp[7:0]);
      end else begin
         iv32 = 1'b1; op32 = op; l32 = l; r32 = r; q32.push_back(exp);
      end
      @(posedge clk); #1;
      // Scramble the inputs: they must be ignored once accepted
      iv8 = 1'b0; iv32 = 1'b0;
      l32 = $urandom; r32 = $urandom; op32 = 5'($urandom_range(0, 17));
      l8 = 8'($urandom); r8 = 8'($urandom); op8 = 5'($urandom_range(0, 17));
      n = 1;
      while (!(w8 ? ov8 : ov32) && n < 100) begin @(posedge clk); #1; n++; end
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_ready_in_done"}, 64'(w8 ? ir8 : ir32), 64'(0));
      if (w8 ? or8 : or32) begin @(posedge clk); #1; end
   endtask

   initial begin
      int seen;
      rst = 1'b1; flush = 1'b0;
      iv32 = 1'b0; op32 = '0; l32 = '0; r32 = '0; or32 = 1'b1;
      iv8  = 1'b0; op8  = '0; l8  = '0; r8  = '0; or8  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready32", 64'(ir32), 64'(0));
      check("rst_out_valid32", 64'(ov32), 64'(0));
      check("rst_result32", 64'(res32), 64'(0));
      check("rst_in_ready8", 64'(ir8), 64'(0));
      rst = 1'b0;
      #1;
      check("post_rst_in_ready32", 64'(ir32), 64'(1));

      // Single-cycle ops
      run_op(0, SUB,  32'h5,        32'h7,        32'hFFFF_FFFE, 1, "sub");
      run_op(0, ADD,  32'hFFFF_FFFF, 32'h2,       32'h1,         1, "add_wrap");
      run_op(0, XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, "xor");
      run_op(0, SLL,  32'h1,        32'h21,       32'h2,         1, "sll_mask");
      run_op(0, SRL,  32'h8000_0000, 32'h1F,      32'h1,         1, "srl");
      run_op(0, SRA,  32'h8000_0000, 32'h24,      32'hF800_0000, 1, "sra");
      run_op(0, SLT,  32'hFFFF_FFFF, 32'h1,       32'h1,         1, "slt");
      run_op(0, SLTU, 32'hFFFF_FFFF, 32'h1,       32'h0,         1, "sltu");
      run_op(0, 5'd20, 32'h1234,    32'h5678,     32'h0,         1, "bad_op");

      // Iterative multiply
      run_op(0, MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, 33, "mul");
      run_op(0, MUL,    32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFF1, 33, "mul_neg");
      run_op(0, MULH,   32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 33, "mulh_neg");
      run_op(0, MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min");
      run_op(0, MULHSU, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33, "mulhsu");
      run_op(0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");

      // Iterative divide and the early-out cases
      run_op(0, DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33, "div_neg");
      run_op(0, REM,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33, "rem_neg");
      run_op(0, DIV,  32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_negdiv");
      run_op(0, REM,  32'h7,         32'hFFFF_FFFE, 32'h1,         33, "rem_negdiv");
      run_op(0, DIVU, 32'd100,       32'd7,         32'd14,        33, "divu");
      run_op(0, REMU, 32'd100,       32'd7,         32'd2,         33, "remu");
      run_op(0, DIVU, 32'h55,        32'h0,         32'hFFFF_FFFF, 1,  "divu_by0");
      run_op(0, REM,  32'h1234,      32'h0,         32'h1234,      1,  "rem_by0");
      run_op(0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
      run_op(0, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  "rem_ovf");

      // Backpressure: result must hold while the consumer stalls
      or32 = 1'b0;
      run_op(0, ADD, 32'h1, 32'h2, 32'h3, 1, "bp");
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_hold_valid", 64'(ov32), 64'(1));
         check("bp_hold_result", 64'(res32), 64'(3));
         check("bp_hold_ready", 64'(ir32), 64'(0));
      end
      or32 = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 64'(ov32), 64'(0));
      check("bp_release_ready", 64'(ir32), 64'(1));

      // Flush at BUSY cycle 10 of a DIVU; nothing may come out for it
      iv32 = 1'b1; op32 = DIVU; l32 = 32'd1000; r32 = 32'd3;
      @(posedge clk); #1;
      iv32 = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("flush_busy_ready", 64'(ir32), 64'(0));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_idle_ready", 64'(ir32), 64'(1));
      check("flush_result", 64'(res32), 64'(0));
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (ov32) seen++; end
      check("flush_no_out", 64'(seen), 64'(0));
      run_op(0, DIVU, 32'd1000, 32'd3, 32'd333, 33, "after_flush");

      // flush together with in_valid in IDLE must not accept
      iv32 = 1'b1; op32 = ADD; l32 = 32'h9; r32 = 32'h9; flush = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0; flush = 1'b0;
      check("flush_req_ready", 64'(ir32), 64'(1));
      check("flush_req_valid", 64'(ov32), 64'(0));
      seen = 0;
      repeat (3) begin @(posedge clk); #1; if (ov32) seen++; end
      check("flush_req_no_out", 64'(seen), 64'(0));

      // XLEN=8 instance
      run_op(1, MUL,   32'h10, 32'h10, 32'h00, 9, "mul8");
      run_op(1, MULHU, 32'h10, 32'h10, 32'h01, 9, "mulhu8");
      iv8 = 1'b1; op8 = MUL; l8 = 8'h0F; r8 = 8'h0F;
      @(posedge clk); #1;
      iv8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst8_ready_during", 64'(ir8), 64'(0));
      rst = 1'b0;
      #1;
      check("rst8_valid", 64'(ov8), 64'(0));
      check("rst8_result", 64'(res8), 64'(0));
      check("rst8_ready", 64'(ir8), 64'(1));
      seen = 0;
      repeat (15) begin @(posedge clk); #1; if (ov8) seen++; end
      check("rst8_no_out", 64'(seen), 64'(0));
      run_op(1, MUL, 32'h0F, 32'h0F, 32'hE1, 9, "mul8_after_rst");

      check("drain32", 64'(q32.size()), 64'(0));
      check("drain8", 64'(q8.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
